// File: rtl/memory_round_ctrl.sv
// Multi-round sequencer for the memorization game: latch a target, show it for a
// window that shrinks each round, collect keypad digits, score, and end in WIN or OVER.
module memory_round_ctrl #(
  parameter int DIGITS         = 4,
  parameter int SHOW_CYCLES    = 500000000,
  parameter int SHOW_STEP      = 100000000,
  parameter int MIN_SHOW       = 100000000,
  parameter int MAX_ROUNDS     = 5,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CW             = 30
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [4*DIGITS-1:0]               rand_in,
  input  logic                              key_valid,
  input  logic [3:0]                        key_value,
  output logic [4*DIGITS-1:0]               target,
  output logic [4*DIGITS-1:0]               entry,
  output logic [$clog2(DIGITS+1)-1:0]       entry_count,
  output logic                              show_target,
  output logic                              result_valid,
  output logic                              result_correct,
  output logic [$clog2(MAX_ROUNDS+1)-1:0]   round,
  output logic [$clog2(MAX_ROUNDS+1)-1:0]   score,
  output logic [2:0]                        state
);

  localparam int EW = 4 * DIGITS;
  localparam int NW = $clog2(DIGITS + 1);
  localparam int RW = $clog2(MAX_ROUNDS + 1);
  localparam int LW = CW + 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHOW  = 3'd1,
    INPUT = 3'd2,
    CHECK = 3'd3,
    WAIT  = 3'd4,
    WIN   = 3'd5,
    OVER  = 3'd6
  } ctrlState_t;

  ctrlState_t stateReg, nextState;
  logic [CW-1:0] showCnt;
  logic [CW-1:0] idleCnt;
  logic [EW-1:0] shiftedEntry;
  logic [RW-1:0] nextRound;
  logic          beginRound, acceptKey, timedOut, resolve, passed;

  // Shrinking window with a floor; the wide intermediate keeps the subtraction from wrapping.
  function automatic logic [LW-1:0] showLen(input logic [RW-1:0] r);
    logic [LW-1:0] dec;
    logic [LW-1:0] len;
    dec = LW'(SHOW_STEP) * (LW'(r) - LW'(1));
    len = (LW'(SHOW_CYCLES) > dec) ? LW'(SHOW_CYCLES) - dec : '0;
    if (len < LW'(MIN_SHOW)) len = LW'(MIN_SHOW);
    return len;
  endfunction

  if (DIGITS == 1) begin : g_oneDigit
    assign shiftedEntry = key_value;
  end else begin : g_multiDigit
    assign shiftedEntry = {entry[EW-5:0], key_value};
  end

  assign nextRound = (stateReg == WAIT) ? round + RW'(1) : RW'(1);
  assign state     = stateReg;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    nextState  = stateReg;
    beginRound = 1'b0;
    acceptKey  = 1'b0;
    timedOut   = 1'b0;
    resolve    = 1'b0;
    passed     = 1'b0;
    case (stateReg)
      IDLE, WAIT, WIN, OVER: begin
        if (start) begin
          beginRound = 1'b1;
          nextState  = SHOW;
        end
      end
      SHOW: if (showCnt <= CW'(1)) nextState = INPUT;
      INPUT: begin
        if (key_valid) begin
          acceptKey = 1'b1;
          if (entry_count == NW'(DIGITS - 1)) nextState = CHECK;
        end else if (TIMEOUT_CYCLES > 0 && idleCnt == CW'(TIMEOUT_CYCLES - 1)) begin
          timedOut  = 1'b1;
          nextState = OVER;
        end
      end
      CHECK: begin
        resolve = 1'b1;
        passed  = (entry == target);
        if (!passed)                          nextState = OVER;
        else if (round == RW'(MAX_ROUNDS))    nextState = WIN;
        else                                  nextState = WAIT;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) stateReg <= IDLE;
    else      stateReg <= nextState;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target         <= '0;
      entry          <= '0;
      entry_count    <= '0;
      show_target    <= 1'b0;
      result_valid   <= 1'b0;
      result_correct <= 1'b0;
      round          <= '0;
      score          <= '0;
      showCnt        <= '0;
      idleCnt        <= '0;
    end else begin
      result_valid <= resolve | timedOut;
      show_target  <= (nextState == SHOW);

      if (beginRound) begin
        target      <= rand_in;
        entry       <= '0;
        entry_count <= '0;
        showCnt     <= CW'(showLen(nextRound));
        idleCnt     <= '0;
        round       <= nextRound;
        if (stateReg != WAIT) score <= '0;
      end else if (stateReg == SHOW && showCnt != '0) begin
        showCnt <= showCnt - CW'(1);
      end

      if (acceptKey) begin
        entry       <= shiftedEntry;
        entry_count <= entry_count + NW'(1);
        idleCnt     <= '0;
      end else if (stateReg == INPUT) begin
        idleCnt <= idleCnt + CW'(1);
      end

      if (timedOut) result_correct <= 1'b0;
      if (resolve) begin
        result_correct <= passed;
        if (passed) score <= score + RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_memory_round_ctrl.sv
// Scoreboard bench for memory_round_ctrl: two instances (step 3 with timeout, step 5 without)
// share stimulus; monitors compare result pulses and show-window lengths against queued expectations.
module tb_memory_round_ctrl;

  localparam int DIGITS = 4, SHOW_CYCLES = 10, SHOW_STEP = 3, MIN_SHOW = 4;
  localparam int MAX_ROUNDS = 3, TIMEOUT_CYCLES = 20, CW = 30;
  localparam int STEP_B = 5;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, key_valid = 1'b0;
  logic [15:0] rand_in = '0;
  logic [3:0]  key_value = '0;

  logic [15:0] a_target, a_entry, b_target, b_entry;
  logic [2:0]  a_count, b_count, a_state, b_state;
  logic [1:0]  a_round, a_score, b_round, b_score;
  logic        a_show, a_rv, a_rc, b_show, b_rv, b_rc;

  memory_round_ctrl #(.DIGITS(DIGITS), .SHOW_CYCLES(SHOW_CYCLES), .SHOW_STEP(SHOW_STEP),
    .MIN_SHOW(MIN_SHOW), .MAX_ROUNDS(MAX_ROUNDS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CW(CW)) dut_a (
    .clk(clk), .rst(rst), .start(start), .rand_in(rand_in), .key_valid(key_valid),
    .key_value(key_value), .target(a_target), .entry(a_entry), .entry_count(a_count),
    .show_target(a_show), .result_valid(a_rv), .result_correct(a_rc), .round(a_round),
    .score(a_score), .state(a_state));

  memory_round_ctrl #(.DIGITS(DIGITS), .SHOW_CYCLES(SHOW_CYCLES), .SHOW_STEP(STEP_B),
    .MIN_SHOW(MIN_SHOW), .MAX_ROUNDS(MAX_ROUNDS), .TIMEOUT_CYCLES(0), .CW(CW)) dut_b (
    .clk(clk), .rst(rst), .start(start), .rand_in(rand_in), .key_valid(key_valid),
    .key_value(key_value), .target(b_target), .entry(b_entry), .entry_count(b_count),
    .show_target(b_show), .result_valid(b_rv), .result_correct(b_rc), .round(b_round),
    .score(b_score), .state(b_state));

  always #5 clk = ~clk;

  typedef struct {
    logic        correct;
    int          score;
    int          st;
    int          rnd;
    logic [15:0] entry;
    int          edgeAt;
  } result_t;

  result_t sbQ[$];
  int      showQA[$], showQB[$];
  int      nChecks = 0, nFails = 0;
  int      cyc = 0;
  int      lastKeyEdge = 0;
  int      gRound = 0, gScore = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int showLen(input int r, input int step);
    int v;
    v = SHOW_CYCLES - (r - 1) * step;
    if (v < MIN_SHOW) v = MIN_SHOW;
    return v;
  endfunction

  // Result monitor: every result_valid pulse must match the oldest queued expectation.
  bit prevRv = 1'b0;
  always @(negedge clk) begin : resultMonitor
    result_t e;
    if (!rst) prevRv = 1'b0;
    else begin
      if (prevRv) check("rv_pulse_width", a_rv, 0);
      if (a_rv) begin
        if (sbQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("FAIL unexpected_result: result_valid high with nothing expected");
        end else begin
          e = sbQ.pop_front();
          check("res_correct", a_rc, e.correct);
          check("res_score", a_score, e.score);
          check("res_state", a_state, e.st);
          check("res_round", a_round, e.rnd);
          check("res_entry", a_entry, e.entry);
          check("res_edge", cyc, e.edgeAt);
        end
      end
      prevRv = a_rv;
    end
  end

  int runA = 0, runB = 0;
  always @(negedge clk) begin
    if (!rst) runA = 0;
    else if (a_show) runA++;
    else if (runA > 0) begin
      if (showQA.size() == 0) begin
        nChecks++; nFails++;
        $display("FAIL showA_unexpected: window of %0d cycles, none expected", runA);
      end else check("showA_len", runA, showQA.pop_front());
      runA = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) runB = 0;
    else if (b_show) runB++;
    else if (runB > 0) begin
      if (showQB.size() == 0) begin
        nChecks++; nFails++;
        $display("FAIL showB_unexpected: window of %0d cycles, none expected", runB);
      end else check("showB_len", runB, showQB.pop_front());
      runB = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic beginRound(input logic [15:0] tgt, input bit newGame);
    if (newGame) begin gRound = 1; gScore = 0; end
    else gRound++;
    showQA.push_back(showLen(gRound, SHOW_STEP));
    showQB.push_back(showLen(gRound, STEP_B));
    rand_in = tgt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    rand_in = 16'($urandom);
  endtask

  task automatic waitShowEnd();
    int budget;
    budget = 200;
    while (a_state != 3'd2 && budget > 0) begin
      tick(1);
      budget--;
    end
    if (budget == 0) check("show_end_timeout", 0, 1);
  endtask

  task automatic sendKey(input logic [3:0] v);
    key_value = v;
    key_valid = 1'b1;
    tick(1);
    key_valid = 1'b0;
    key_value = 4'($urandom);
    lastKeyEdge = cyc;
  endtask

  task automatic expectCheck(input logic [15:0] ent, input bit correct);
    result_t e;
    if (correct) gScore++;
    e.correct = correct;
    e.score   = gScore;
    e.st      = !correct ? 6 : (gRound == MAX_ROUNDS ? 5 : 4);
    e.rnd     = gRound;
    e.entry   = ent;
    e.edgeAt  = lastKeyEdge + 1;
    sbQ.push_back(e);
  endtask

  task automatic enterDigits(input logic [15:0] tgt, input bit wrongLast);
    logic [15:0] ent;
    ent = tgt;
    if (wrongLast) ent[3:0] = tgt[3:0] + 4'd1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      tick($urandom_range(0, 3));
      sendKey(ent[4*i +: 4]);
    end
    expectCheck(ent, !wrongLast);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [15:0] tgt;
    result_t     e;

    tick(2);
    check("rst_state", a_state, 0);
    check("rst_round", a_round, 0);
    check("rst_target", a_target, 0);
    check("rst_show", a_show, 0);
    rst = 1'b1;
    tick(2);

    // Round 1 with ignored events mixed in.
    beginRound(16'h3A7C, 1'b1);
    tick(3);
    key_value = 4'h5; key_valid = 1'b1; rand_in = 16'hFFFF;
    tick(1);
    key_valid = 1'b0;
    check("show_key_ignored_cnt", a_count, 0);
    check("show_state", a_state, 1);
    waitShowEnd();
    check("in_entry_clean", a_entry, 0);
    check("in_target_held", a_target, 16'h3A7C);
    sendKey(4'h3);
    sendKey(4'hA);
    start = 1'b1; rand_in = 16'h0F0F;
    tick(1);
    start = 1'b0;
    check("start_in_input_state", a_state, 2);
    check("start_in_input_cnt", a_count, 2);
    start = 1'b1;
    sendKey(4'h7);
    start = 1'b0;
    check("start_key_state", a_state, 2);
    check("start_key_entry", a_entry, 16'h03A7);
    sendKey(4'hC);
    expectCheck(16'h3A7C, 1'b1);
    tick(4);
    check("r1_state_wait", a_state, 4);

    // Rounds 2 and 3 with random targets.
    for (int r = 2; r <= MAX_ROUNDS; r++) begin
      tgt = 16'($urandom);
      beginRound(tgt, 1'b0);
      waitShowEnd();
      check("rnd_target", a_target, tgt);
      enterDigits(tgt, 1'b0);
      tick(4);
    end
    check("win_state", a_state, 5);
    check("win_score", a_score, 3);

    // New game: one pass, then a wrong entry.
    tgt = 16'($urandom);
    beginRound(tgt, 1'b1);
    check("restart_round", a_round, 1);
    check("restart_score", a_score, 0);
    waitShowEnd();
    enterDigits(tgt, 1'b0);
    tick(3);
    beginRound(16'h1234, 1'b0);
    waitShowEnd();
    enterDigits(16'h1234, 1'b1);
    tick(4);
    check("wrong_state", a_state, 6);
    check("wrong_score_kept", a_score, 1);

    // Idle-key timeout after two digits.
    tgt = 16'($urandom);
    beginRound(tgt, 1'b1);
    check("over_restart_round", a_round, 1);
    check("over_restart_score", a_score, 0);
    waitShowEnd();
    sendKey(tgt[15:12]);
    sendKey(tgt[11:8]);
    e.correct = 1'b0; e.score = 0; e.st = 6; e.rnd = 1;
    e.entry = {8'h00, tgt[15:8]}; e.edgeAt = lastKeyEdge + TIMEOUT_CYCLES;
    sbQ.push_back(e);
    tick(TIMEOUT_CYCLES + 5);
    check("timeout_state", a_state, 6);
    check("no_timeout_state", b_state, 2);
    check("no_timeout_cnt", b_count, 2);

    // Asynchronous reset in the middle of SHOW.
    rand_in = 16'($urandom);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    check("pre_reset_show", a_show, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("areset_state", a_state, 0);
    check("areset_show", a_show, 0);
    check("areset_target", a_target, 0);
    check("areset_round", a_round, 0);
    check("areset_score", a_score, 0);
    check("areset_rv", a_rv, 0);
    check("areset_b_state", b_state, 0);
    tick(2);
    rst = 1'b1;
    tick(3);
    check("post_reset_idle", a_state, 0);
    check("post_reset_rv", a_rv, 0);

    check("sb_empty", sbQ.size(), 0);
    check("showA_empty", showQA.size(), 0);
    check("showB_empty", showQB.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/memory_round_ctrl.md
Name: memory_round_ctrl

Overview:
Parametrised round sequencer for the memorization game. It replaces the single fixed display delay with a multi-round controller. Each round it latches a random target, shows it for a window that shrinks per round, then collects keypad digits. It compares the entry to the target, keeps score, and ends in a WIN or OVER state. It sits between randnum/keyboard_decoder and display: its show_target output drives the display phase, and its result outputs drive the result display.

Parameters:
DIGITS, 4, number of hex digits per target/entry (1..8)
SHOW_CYCLES, 500000000, show duration for round 1, in clk cycles
SHOW_STEP, 100000000, amount the show duration shrinks each later round
MIN_SHOW, 100000000, floor on the show duration
MAX_ROUNDS, 5, number of rounds needed to win (>=1)
TIMEOUT_CYCLES, 0, idle-key timeout during INPUT; 0 disables it
CW, 30, width of the show/timeout counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low; rst=0 clears all state
start  in  1  single-cycle pulse: begin game / continue to next round / restart
rand_in  in  4*DIGITS  random value, sampled only when a round begins
key_valid  in  1  single-cycle strobe, one new keypad digit
key_value  in  4  digit carried by key_valid
target  out  4*DIGITS  latched target for the current round
entry  out  4*DIGITS  digits entered so far, most recent digit in the low nibble
entry_count  out  clog2(DIGITS+1)  number of digits entered this round
show_target  out  1  high while state is SHOW
result_valid  out  1  one-cycle pulse when a round resolves
result_correct  out  1  outcome of the last resolved round; holds until the next resolve
round  out  clog2(MAX_ROUNDS+1)  current round number, 1-based; 0 in IDLE
score  out  clog2(MAX_ROUNDS+1)  rounds passed in the current game
state  out  3  IDLE=0 SHOW=1 INPUT=2 CHECK=3 WAIT=4 WIN=5 OVER=6

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs and counters are 0.
- All outputs are registered.
- show_len(r) = max(SHOW_CYCLES - (r-1)*SHOW_STEP, MIN_SHOW). Compute in CW+8 bits with saturation, so it never underflows.
- Round begin (from IDLE/WAIT/WIN/OVER on start):
  - target<=rand_in; entry<=0; entry_count<=0.
  - Load the show counter with show_len.
  - round<=1 and score<=0 from IDLE/WIN/OVER; round<=round+1 from WAIT.
  - Next state SHOW.
- SHOW:
  - show_target=1.
  - SHOW lasts exactly show_len cycles, then enters INPUT.
  - key_valid is ignored.
- INPUT:
  - On key_valid: entry<={entry[4*DIGITS-5:0],key_value}; entry_count++; timeout counter reset.
  - When entry_count reaches DIGITS, state goes to CHECK on the following cycle.
  - If TIMEOUT_CYCLES>0 and TIMEOUT_CYCLES consecutive cycles pass with no key_valid: result_valid pulse, result_correct=0, state goes to OVER.
- CHECK (1 cycle): compare entry==target, then pulse result_valid and set result_correct.
  - Correct: score++; next state is WIN if round==MAX_ROUNDS, else WAIT.
  - Wrong: next state OVER.
- WAIT/WIN/OVER: hold all outputs until start.
- Latency: last digit in cycle t gives CHECK at t+1 and result_valid high at t+2.
- start is ignored in SHOW, INPUT and CHECK, including when it coincides with key_valid.
- key_valid outside INPUT is ignored.
- rand_in changes outside round begin have no effect.
- Asserting rst in any state aborts the game immediately; there is no partial result_valid.

Test Plan:
Default parameters for all scenarios: DIGITS=4, SHOW_CYCLES=10, SHOW_STEP=3, MIN_SHOW=4, MAX_ROUNDS=3, TIMEOUT_CYCLES=20.
1. Round 1 pass: start with rand_in=16'h3A7C -> show_target high exactly 10 cycles. Keys 3,A,7,C -> result_valid one cycle 2 cycles after C, result_correct=1, score=1, state=WAIT.
2. Shrinking show window: continue through rounds 2 and 3 -> show windows of 7 cycles, then 4 cycles. Passing round 3 -> state=WIN, score=3. Configuring SHOW_STEP=5 -> round-3 window clamped to 4 cycles.
3. Wrong entry: target 16'h1234, keys 1,2,3,5 -> result_correct=0, state=OVER, score unchanged. A following start -> round=1, score=0.
4. Timeout: after entering 2 digits, send no keys for 20 cycles -> result_valid with result_correct=0, state=OVER. Same stimulus with TIMEOUT_CYCLES=0 -> stays in INPUT.
5. Ignored events: key_valid during SHOW, and start during INPUT -> entry, entry_count and state unaffected; rand_in toggling mid-round does not change target.
6. Async reset: drop rst mid-SHOW, between clock edges -> all outputs 0 and state=IDLE immediately, with no result_valid pulse.
